// File: rtl/host_req_sched_if.sv
// host_req_sched_if
//   Bundles the channel request, host request and host response handshakes
//   around the host request scheduler.
//   Channel side : i_req_v/i_req_r plus packed i_req_sid/i_req_ea, channel c
//                  at [c*width +: width].
//   Host request : o_req_v/o_req_r with o_req_sid/o_req_ea.
//   Host response: i_rsp_v/i_rsp_r with i_rsp_sid.
//   master = scheduler view, slave = surrounding logic / testbench view.
interface host_req_sched_if #(
    parameter int unsigned addr_width   = 64,
    parameter int unsigned nstrms_width = 6,
    parameter int unsigned channels     = 4
);
    logic [channels-1:0]              i_req_v;
    logic [channels-1:0]              i_req_r;
    logic [channels*nstrms_width-1:0] i_req_sid;
    logic [channels*addr_width-1:0]   i_req_ea;

    logic                             o_req_v;
    logic                             o_req_r;
    logic [nstrms_width-1:0]          o_req_sid;
    logic [addr_width-1:0]            o_req_ea;

    logic                             i_rsp_v;
    logic                             i_rsp_r;
    logic [nstrms_width-1:0]          i_rsp_sid;

    modport master (
        input  i_req_v, i_req_sid, i_req_ea, o_req_r, i_rsp_v, i_rsp_sid,
        output i_req_r, o_req_v, o_req_sid, o_req_ea, i_rsp_r
    );

    modport slave (
        output i_req_v, i_req_sid, i_req_ea, o_req_r, i_rsp_v, i_rsp_sid,
        input  i_req_r, o_req_v, o_req_sid, o_req_ea, i_rsp_r
    );
endinterface

// File: rtl/host_req_sched.sv
// host_req_sched
//   Round-robin scheduler of L2 channel read requests onto the single host
//   request port, with one registered output stage and a global credit
//   counter limiting host reads in flight.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low reset
//   bus     : host_req_sched_if.master (channel requests, host request,
//             host response handshakes)
//   o_outst : requests accepted but not yet answered
//   o_err   : sticky, a response arrived while nothing was outstanding
module host_req_sched #(
    parameter int unsigned addr_width   = 64,
    parameter int unsigned nstrms       = 64,
    parameter int unsigned nstrms_width = $clog2(nstrms),
    parameter int unsigned channels     = 4,
    parameter int unsigned max_outst    = 32,
    parameter int unsigned outst_width  = $clog2(max_outst + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    host_req_sched_if.master       bus,
    output logic [outst_width-1:0] o_outst,
    output logic                   o_err
);
    localparam int unsigned ch_width = $clog2(channels);
    localparam logic [outst_width-1:0] max_cnt = outst_width'(max_outst);
    localparam logic [ch_width-1:0]    last_ch = ch_width'(channels - 1);

    logic [ch_width-1:0]     ptr_q, ptr_d;
    logic                    o_req_v_q, o_req_v_d;
    logic [nstrms_width-1:0] sid_q, sid_d;
    logic [addr_width-1:0]   ea_q, ea_d;
    logic [outst_width-1:0]  outst_q, outst_d;
    logic                    err_q, err_d;

    logic                    found;
    logic [ch_width-1:0]     winner;
    logic [ch_width-1:0]     idx_c;
    int unsigned             idx;
    logic                    free, cred, accept, rsp_acc, underflow;
    logic [channels-1:0]     grant;

    // Winner search depends only on valids and the pointer, never on ready.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_c  = '0;
        for (int unsigned k = 0; k < channels; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= channels) idx = idx - channels;
            idx_c = ch_width'(idx);
            if (!found && bus.i_req_v[idx_c]) begin
                found  = 1'b1;
                winner = idx_c;
            end
        end
    end

    always_comb begin
        free      = !o_req_v_q || bus.o_req_r;
        cred      = outst_q < max_cnt;
        accept    = found && free && cred && reset;
        rsp_acc   = bus.i_rsp_v && reset;
        underflow = rsp_acc && (outst_q == '0);

        grant = '0;
        if (accept) grant[winner] = 1'b1;

        ptr_d     = ptr_q;
        o_req_v_d = o_req_v_q;
        sid_d     = sid_q;
        ea_d      = ea_q;
        if (accept) begin
            ptr_d     = (winner == last_ch) ? '0 : winner + 1'b1;
            o_req_v_d = 1'b1;
            sid_d     = bus.i_req_sid[32'(winner) * nstrms_width +: nstrms_width];
            ea_d      = bus.i_req_ea[32'(winner) * addr_width +: addr_width];
        end else if (bus.o_req_r) begin
            o_req_v_d = 1'b0;
        end

        // A response with nothing outstanding returns no credit.
        outst_d = outst_q;
        case ({accept, rsp_acc && !underflow})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        err_d = err_q || underflow;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            o_req_v_q <= 1'b0;
            sid_q     <= '0;
            ea_q      <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            o_req_v_q <= o_req_v_d;
            sid_q     <= sid_d;
            ea_q      <= ea_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    assign bus.i_req_r   = grant;
    assign bus.o_req_v   = o_req_v_q;
    assign bus.o_req_sid = sid_q;
    assign bus.o_req_ea  = ea_q;
    assign bus.i_rsp_r   = reset;
    assign o_outst       = outst_q;
    assign o_err         = err_q;
endmodule

// File: tb/tb_host_req_sched.sv
// tb_host_req_sched
//   Directed bench for host_req_sched: a vector table for arbitration,
//   drain and credit behaviour, plus hand-written multi-cycle sequences
//   for reset, single request, credit exhaustion, backpressure and
//   asynchronous reset mid-traffic.
module tb_host_req_sched;
    localparam int unsigned AW = 64;
    localparam int unsigned NW = 6;
    localparam int unsigned CH = 4;
    localparam int unsigned MO = 32;
    localparam int unsigned OW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [OW-1:0] o_outst;
    logic          o_err;

    always #5 clk = ~clk;

    host_req_sched_if #(.addr_width(AW), .nstrms_width(NW), .channels(CH)) bus ();

    host_req_sched #(
        .addr_width(AW), .nstrms(64), .nstrms_width(NW),
        .channels(CH), .max_outst(MO), .outst_width(OW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master),
        .o_outst(o_outst), .o_err(o_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [NW-1:0] sid, input logic [AW-1:0] ea);
        bus.i_req_sid[c*NW +: NW] = sid;
        bus.i_req_ea[c*AW +: AW]  = ea;
    endtask

    function automatic logic [NW-1:0] def_sid(input int c);
        return NW'(10 + c);
    endfunction

    function automatic logic [AW-1:0] def_ea(input int c);
        return 64'h1000 * 64'(c + 1);
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        bus.i_req_v = '0;
        bus.o_req_r = 1'b0;
        bus.i_rsp_v = 1'b0;
        bus.i_rsp_sid = '0;
        for (int c = 0; c < CH; c++) set_ch(c, def_sid(c), def_ea(c));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req_v;
        logic       ordy;
        logic       rsp;
        logic [3:0] e_rdy;
        logic       e_v;
        int         e_ch;
        logic [5:0] e_out;
        logic       e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;

        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0, 6'd1, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1, 6'd1, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2, 6'd1, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 3, 6'd1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 0, 6'd1, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 6'd0, 1'b0};
        tbl[6]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 6'd1, 1'b0};
        tbl[7]  = '{4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 1, 6'd1, 1'b0};
        tbl[8]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 3, 6'd2, 1'b0};
        tbl[9]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2, 6'd2, 1'b0};
        tbl[10] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 3, 6'd3, 1'b0};
        tbl[11] = '{4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 0, 6'd3, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 0, 6'd2, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 6'd1, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 6'd0, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 6'd0, 1'b1};

        // Reset held with every channel requesting.
        bus.i_req_v   = '1;
        bus.o_req_r   = 1'b1;
        bus.i_rsp_v   = 1'b0;
        bus.i_rsp_sid = '0;
        for (int c = 0; c < CH; c++) set_ch(c, def_sid(c), def_ea(c));
        repeat (2) @(posedge clk);
        #2;
        chk("rst o_req_v", 64'(bus.o_req_v), 64'd0);
        chk("rst i_req_r", 64'(bus.i_req_r), 64'd0);
        chk("rst i_rsp_r", 64'(bus.i_rsp_r), 64'd0);
        chk("rst o_outst", 64'(o_outst), 64'd0);
        chk("rst o_err",   64'(o_err), 64'd0);

        // Single request from channel 2.
        do_reset();
        chk("rsp_r out of reset", 64'(bus.i_rsp_r), 64'd1);
        set_ch(2, 6'd5, 64'h1000);
        bus.i_req_v = 4'b0100;
        bus.o_req_r = 1'b1;
        #2;
        chk("single i_req_r", 64'(bus.i_req_r), 64'b0100);
        tick();
        bus.i_req_v = '0;
        chk("single o_req_v", 64'(bus.o_req_v), 64'd1);
        chk("single sid", 64'(bus.o_req_sid), 64'd5);
        chk("single ea", bus.o_req_ea, 64'h1000);
        chk("single outst", 64'(o_outst), 64'd1);

        // Vector table: fairness, drain, holding, credit return, underflow.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.i_req_v = tbl[i].req_v;
            bus.o_req_r = tbl[i].ordy;
            bus.i_rsp_v = tbl[i].rsp;
            #2;
            chk($sformatf("vec%0d i_req_r", i), 64'(bus.i_req_r), 64'(tbl[i].e_rdy));
            tick();
            chk($sformatf("vec%0d o_req_v", i), 64'(bus.o_req_v), 64'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d sid", i), 64'(bus.o_req_sid), 64'(def_sid(tbl[i].e_ch)));
                chk($sformatf("vec%0d ea", i), bus.o_req_ea, def_ea(tbl[i].e_ch));
            end
            chk($sformatf("vec%0d outst", i), 64'(o_outst), 64'(tbl[i].e_out));
            chk($sformatf("vec%0d err", i), 64'(o_err), 64'(tbl[i].e_err));
        end
        bus.i_rsp_v = 1'b0;
        tick();
        chk("err sticky", 64'(o_err), 64'd1);
        chk("outst no underflow", 64'(o_outst), 64'd0);

        // Credit exhaustion and single-credit return.
        do_reset();
        bus.i_req_v = '1;
        bus.o_req_r = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (bus.i_req_r != '0) acc++;
            tick();
        end
        chk("credit accepts", 64'(acc), 64'd32);
        chk("credit outst full", 64'(o_outst), 64'd32);
        #2;
        chk("credit blocked", 64'(bus.i_req_r), 64'd0);
        bus.i_rsp_v = 1'b1;
        #1;
        chk("credit blocked during rsp", 64'(bus.i_req_r), 64'd0);
        tick();
        bus.i_rsp_v = 1'b0;
        chk("credit outst 31", 64'(o_outst), 64'd31);
        #2;
        chk("credit reaccept", 64'(bus.i_req_r != '0), 64'd1);
        tick();
        chk("credit outst back 32", 64'(o_outst), 64'd32);
        #2;
        chk("credit blocked again", 64'(bus.i_req_r), 64'd0);

        // Backpressure with channel 1 holding a second request.
        do_reset();
        bus.o_req_r = 1'b0;
        set_ch(1, 6'd7, 64'hABC);
        bus.i_req_v = 4'b0010;
        #2;
        chk("bp first accept", 64'(bus.i_req_r), 64'b0010);
        tick();
        set_ch(1, 6'd8, 64'hDEF);
        for (int i = 0; i < 10; i++) begin
            #2;
            chk($sformatf("bp%0d i_req_r", i), 64'(bus.i_req_r), 64'd0);
            chk($sformatf("bp%0d o_req_v", i), 64'(bus.o_req_v), 64'd1);
            chk($sformatf("bp%0d sid", i), 64'(bus.o_req_sid), 64'd7);
            chk($sformatf("bp%0d ea", i), bus.o_req_ea, 64'hABC);
            tick();
        end
        bus.o_req_r = 1'b1;
        #2;
        chk("bp release i_req_r", 64'(bus.i_req_r), 64'b0010);
        tick();
        bus.i_req_v = '0;
        chk("bp reload o_req_v", 64'(bus.o_req_v), 64'd1);
        chk("bp reload sid", 64'(bus.o_req_sid), 64'd8);
        chk("bp reload ea", bus.o_req_ea, 64'hDEF);
        chk("bp outst", 64'(o_outst), 64'd2);

        // Error flag, then asynchronous reset in the middle of traffic.
        do_reset();
        bus.i_rsp_v = 1'b1;
        tick();
        bus.i_rsp_v = 1'b0;
        chk("err set", 64'(o_err), 64'd1);
        chk("err outst", 64'(o_outst), 64'd0);
        bus.i_req_v = '1;
        bus.o_req_r = 1'b0;
        tick();
        tick();
        chk("pre-reset o_req_v", 64'(bus.o_req_v), 64'd1);
        chk("pre-reset outst", 64'(o_outst), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async o_req_v", 64'(bus.o_req_v), 64'd0);
        chk("async sid", 64'(bus.o_req_sid), 64'd0);
        chk("async ea", bus.o_req_ea, 64'd0);
        chk("async outst", 64'(o_outst), 64'd0);
        chk("async err", 64'(o_err), 64'd0);
        chk("async i_req_r", 64'(bus.i_req_r), 64'd0);
        chk("async i_rsp_r", 64'(bus.i_rsp_r), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
